// File: rtl/ma_load_store_unit.sv
// MA-stage load/store unit: memory request/ack sequencing,
// store lane formatting and load extraction/extension.
module ma_load_store_unit #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busywait,
  output logic        misaligned,
  output logic        timeout_err,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [29:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byteen,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    lane_q;

  logic        req;
  logic        sz_byte;
  logic        sz_half;
  logic        mis;
  logic        accept;
  logic [3:0]  byteen_n;
  logic [31:0] wdata_n;
  logic [31:0] shifted;
  logic [31:0] load_fmt;

  assign req = mem_read | mem_write;

  // Store and load codes decode to access size differently.
  always_comb begin
    sz_byte = 1'b0;
    sz_half = 1'b0;
    if (mem_write) begin
      sz_byte = (funct3 == 3'b000);
      sz_half = (funct3 == 3'b001);
    end else begin
      sz_byte = (funct3 == 3'b000) || (funct3 == 3'b100);
      sz_half = (funct3 == 3'b001) || (funct3 == 3'b101);
    end
  end

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      sz_byte: mis = 1'b0;
      sz_half: mis = address[0];
      default: mis = |address[1:0];
    endcase
  end

  assign accept     = (state == IDLE) && req && !mis;
  assign misaligned = (state == IDLE) && req && mis;
  assign busywait   = accept || (state == ACCESS);

  always_comb begin
    byteen_n = 4'b1111;
    wdata_n  = write_data;
    if (mem_write) begin
      unique case (1'b1)
        sz_byte: begin
          byteen_n = 4'b0001 << address[1:0];
          wdata_n  = {4{write_data[7:0]}};
        end
        sz_half: begin
          byteen_n = address[1] ? 4'b1100 : 4'b0011;
          wdata_n  = {2{write_data[15:0]}};
        end
        default: begin
          byteen_n = 4'b1111;
          wdata_n  = write_data;
        end
      endcase
    end
  end

  assign shifted = dmem_rdata >> {lane_q, 3'b000};

  always_comb begin
    load_fmt = dmem_rdata;
    unique case (f3_q)
      3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_fmt = {24'd0, shifted[7:0]};
      3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_fmt = {16'd0, shifted[15:0]};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state       <= IDLE;
      cnt         <= '0;
      f3_q        <= 3'b000;
      lane_q      <= 2'b00;
      read_data   <= 32'd0;
      timeout_err <= 1'b0;
      dmem_read   <= 1'b0;
      dmem_write  <= 1'b0;
      dmem_addr   <= 30'd0;
      dmem_wdata  <= 32'd0;
      dmem_byteen <= 4'b0000;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            dmem_read   <= !mem_write;
            dmem_write  <= mem_write;
            dmem_addr   <= address[31:2];
            dmem_wdata  <= wdata_n;
            dmem_byteen <= byteen_n;
            f3_q        <= funct3;
            lane_q      <= address[1:0];
            cnt         <= '0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + CW'(1);
          // An ack on the final counted cycle still completes normally.
          if (dmem_ack) begin
            if (dmem_read) read_data <= load_fmt;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            state      <= DONE;
          end else if (cnt == CNT_LAST) begin
            if (dmem_read) read_data <= 32'd0;
            dmem_read   <= 1'b0;
            dmem_write  <= 1'b0;
            timeout_err <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ma_load_store_unit.md
# ma_load_store_unit

Memory-access (MA) stage load/store unit of the RV32IM pipeline: takes the memory-control signals, ALU address and rs2 data from the EX/MA register and runs a request/acknowledge transaction with data memory. It formats store byte lanes, extracts and sign- or zero-extends load data, and stalls the pipeline via `busywait` until the access completes. `read_data` feeds the MA/WB register directly.

## Interface
- `MEM_TIMEOUT`, default 255: maximum number of ACCESS cycles spent waiting for `dmem_ack` before the access is aborted.
- `CLK`  in  1  pipeline clock, rising-edge.
- `RESETn`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  load request from EX/MA.
- `mem_write`  in  1  store request from EX/MA; takes priority if both requests are high.
- `funct3`  in  3  access type.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is a word access.
- `address`  in  32  byte address (ALU_out).
- `write_data`  in  32  rs2 value.
- `read_data`  out  32  registered, formatted load result; to MA/WB.
- `busywait`  out  1  combinational stall to all upstream pipeline registers.
- `misaligned`  out  1  combinational; high when the current request is misaligned.
- `timeout_err`  out  1  sticky abort flag.
- `dmem_read`, `dmem_write`  out  1 each  registered memory strobes.
- `dmem_addr`  out  30  word address (`address[31:2]`), registered.
- `dmem_wdata`  out  32  lane-replicated store data, registered.
- `dmem_byteen`  out  4  store byte enables, registered; 1111 for loads.
- `dmem_rdata`  in  32  memory word.
- `dmem_ack`  in  1  one-cycle completion pulse from memory.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE, accepting a request:
  - Condition: (`mem_read` or `mem_write`) and the request is aligned.
  - Latch the strobe, `dmem_addr`, `dmem_wdata`, `dmem_byteen`, `funct3` and `address[1:0]`.
  - Clear the timeout counter and go to ACCESS.
- ACCESS:
  - Strobes are held stable and the counter increments every cycle.
  - On `dmem_ack`: drop the strobes; for loads, register the formatted `dmem_rdata` into `read_data`; go to DONE.
  - If the counter reaches `MEM_TIMEOUT` without an ack: drop the strobes, set `read_data` = 0 (loads), set `timeout_err` = 1, go to DONE.
  - If the ack arrives in the same cycle the counter reaches `MEM_TIMEOUT`, the ack wins and no error is raised.
- DONE: lasts one cycle, then returns to IDLE. Inputs are ignored in DONE because they still belong to the completed instruction.
- `busywait` = (IDLE and an aligned request) or ACCESS. It is 0 in DONE, so the pipeline advances on the edge that ends DONE.
- Misalignment rules:
  - LH, LHU or SH with `address[0]`=1 is misaligned.
  - LW, SW or any other code with `address[1:0]`≠00 is misaligned.
- A misaligned request raises `misaligned`, issues no memory access and gives `busywait` = 0. `read_data` holds its value.
- Store formatting (lane k = `address[1:0]`):
  - SB: byteen = 1<<k, wdata = {4{wd[7:0]}}.
  - SH: byteen = `address[1]` ? 1100 : 0011, wdata = {2{wd[15:0]}}.
  - SW: byteen = 1111, wdata = wd.
- Load formatting: shift `dmem_rdata` right by 8·k, then extend.
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- `dmem_ack` is ignored in IDLE and DONE.
- `timeout_err` clears only on reset.

## Timing
- Reset values: state IDLE; `read_data`, `dmem_addr`, `dmem_wdata` = 0; `dmem_byteen` = 0000; `dmem_read`, `dmem_write`, `timeout_err`, counter = 0.
- Derived outputs: `busywait` = 0 and `misaligned` = 0 unless an input request is present.
- Cycle sequence:
  - Cycle 0: request in IDLE, `busywait` = 1.
  - Cycle 1: strobes visible.
  - Ack in cycle n ≥ 1 leads to DONE in cycle n+1; the pipeline advances at the end of cycle n+1.
  - Minimum total: 3 cycles per memory instruction.
- Timeout abort: DONE is entered `MEM_TIMEOUT`+1 cycles after the request.
- Reset asserted mid-ACCESS: strobes drop immediately and the block returns to IDLE; no partial result reaches `read_data`.
- Non-memory instructions: `busywait` = 0 and no state change (zero latency).

## Test plan
- LW at 0x100 with `dmem_rdata` = 0xDEADBEEF and ack in cycle 1 → `dmem_addr` = 0x40; `busywait` high for 2 cycles; `read_data` = 0xDEADBEEF in DONE.
- LB at 0x103 with rdata = 0x80123456 → `read_data` = 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x00008012.
- SB at 0x101 with wd = 0x000000AB → byteen = 0010, wdata = 0xABABABAB. SH at 0x102 → byteen = 1100.
- LW at 0x102 → `misaligned` = 1, `busywait` = 0, both strobes stay 0.
- Load with no ack for 255 cycles → strobes drop; `timeout_err` = 1; `read_data` = 0; IDLE after DONE; flag persists into the next access.
- Assert `RESETn` low in ACCESS → immediate IDLE with all outputs at reset values; a back-to-back store after the load executes correctly.
